// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared definitions for the Y86 fetch sequencer: instruction-code values,
// the "no register" specifier and the fetch FSM state encoding.
// ---------------------------------------------------------------------------
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPC,
        S_REG,
        S_CONST,
        S_DONE
    } fetch_state_t;

endpackage

// File: rtl/ifetch_len_dec.sv
// ---------------------------------------------------------------------------
// ifetch_len_dec
// Combinational instruction-format decoder: from the opcode's high nibble it
// derives the total instruction length and which optional fields follow.
// Ports:
//   icode    in   4  instruction code
//   len      out  4  instruction length in bytes (1, 2, 9 or 10)
//   has_reg  out  1  a register-specifier byte follows the opcode
//   has_valc out  1  an 8-byte constant follows
//   invalid  out  1  icode is not a defined Y86 instruction
// ---------------------------------------------------------------------------
module ifetch_len_dec
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len,
    output logic       has_reg,
    output logic       has_valc,
    output logic       invalid
);

    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        len      = 4'd1;
        has_reg  = 1'b0;
        has_valc = 1'b0;
        invalid  = 1'b0;
        case (icode)
            I_HALT, I_NOP, I_RET: begin
                len = 4'd1;
            end
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                len     = 4'd2;
                has_reg = 1'b1;
            end
            I_JXX, I_CALL: begin
                len      = 4'd9;
                has_valc = 1'b1;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                len      = 4'd10;
                has_reg  = 1'b1;
                has_valc = 1'b1;
            end
            default: begin
                invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ifetch_seq.sv
// ---------------------------------------------------------------------------
// ifetch_seq
// Byte-serial Y86 fetch sequencer. Reads one instruction byte per cycle from
// a combinational byte-wide memory, assembles icode/ifun/rA/rB/valC/valP and
// offers the result to decode over a valid/ready handshake. Undefined icodes
// and byte addresses >= MEM_BYTES are reported through ins_err.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   pc_valid/pc_ready     fetch request handshake, pc_in = start address
//   mem_addr/mem_byte     instruction memory read port (same-cycle data)
//   ins_valid/ins_ready   result handshake
//   icode, ifun, rA, rB   decoded opcode and register specifiers
//   valC, valP            constant and next sequential PC
//   ins_err               result is an error (invalid icode or bad address)
// Optional (macro IFETCH_PERF_EN):
//   perf_ins              saturating count of completed result handshakes
//   perf_stall            saturating count of cycles stalled by decode
// ---------------------------------------------------------------------------
module ifetch_seq
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_valid,
    output logic        pc_ready,
    input  logic [63:0] pc_in,
    output logic [63:0] mem_addr,
    input  logic [7:0]  mem_byte,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        ins_err
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_ins,
    output logic [31:0] perf_stall
`endif
);

    localparam logic [63:0] ADDR_LIMIT = 64'(MEM_BYTES);

    fetch_state_t state_q, state_d;
    logic [63:0]  addr_q;
    logic [2:0]   cbyte_q;      // index of the next valC byte

    logic [3:0]   dec_icode;
    logic [3:0]   dec_len;
    logic         dec_has_reg;
    logic         dec_has_valc;
    logic         dec_invalid;
    logic         oob;

    // In OPC the opcode is still on the memory bus; afterwards the captured
    // icode tells REG whether a constant follows.
    assign dec_icode = (state_q == S_OPC) ? mem_byte[7:4] : icode;

    ifetch_len_dec u_len_dec (
        .icode   (dec_icode),
        .len     (dec_len),
        .has_reg (dec_has_reg),
        .has_valc(dec_has_valc),
        .invalid (dec_invalid)
    );

    assign oob      = (addr_q >= ADDR_LIMIT);
    assign mem_addr = (state_q inside {S_OPC, S_REG, S_CONST}) ? addr_q : 64'd0;

    always_comb begin
        state_d   = state_q;
        pc_ready  = 1'b0;
        ins_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                pc_ready = 1'b1;
                if (pc_valid) state_d = S_OPC;
            end
            S_OPC: begin
                if (oob || dec_invalid || dec_len == 4'd1) state_d = S_DONE;
                else if (dec_has_reg)                      state_d = S_REG;
                else                                       state_d = S_CONST;
            end
            S_REG: begin
                if (oob || !dec_has_valc) state_d = S_DONE;
                else                      state_d = S_CONST;
            end
            S_CONST: begin
                if (oob || cbyte_q == 3'd7) state_d = S_DONE;
            end
            S_DONE: begin
                ins_valid = 1'b1;
                if (ins_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= 64'd0;
            cbyte_q <= 3'd0;
            icode   <= 4'h0;
            ifun    <= 4'h0;
            rA      <= REG_NONE;
            rB      <= REG_NONE;
            valC    <= 64'd0;
            valP    <= 64'd0;
            ins_err <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (pc_valid) begin
                        // Fresh instruction: clear all fields; valP = pc_in
                        // stands unless the fetch completes cleanly.
                        addr_q  <= pc_in;
                        valP    <= pc_in;
                        cbyte_q <= 3'd0;
                        icode   <= 4'h0;
                        ifun    <= 4'h0;
                        rA      <= REG_NONE;
                        rB      <= REG_NONE;
                        valC    <= 64'd0;
                        ins_err <= 1'b0;
                    end
                end
                S_OPC: begin
                    if (oob) begin
                        ins_err <= 1'b1;
                    end else begin
                        icode  <= mem_byte[7:4];
                        ifun   <= mem_byte[3:0];
                        addr_q <= addr_q + 64'd1;
                        if (dec_invalid)            ins_err <= 1'b1;
                        else if (dec_len == 4'd1)   valP    <= addr_q + 64'd1;
                    end
                end
                S_REG: begin
                    if (oob) begin
                        ins_err <= 1'b1;
                    end else begin
                        rA     <= mem_byte[7:4];
                        rB     <= mem_byte[3:0];
                        addr_q <= addr_q + 64'd1;
                        if (!dec_has_valc) valP <= addr_q + 64'd1;
                    end
                end
                S_CONST: begin
                    if (oob) begin
                        // An incomplete constant is reported as absent.
                        ins_err <= 1'b1;
                        valC    <= 64'd0;
                    end else begin
                        valC[{cbyte_q, 3'b000} +: 8] <= mem_byte;
                        addr_q  <= addr_q + 64'd1;
                        cbyte_q <= cbyte_q + 3'd1;
                        if (cbyte_q == 3'd7) valP <= addr_q + 64'd1;
                    end
                end
                S_DONE: begin
                    if (ins_ready) ins_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ins   <= 32'd0;
            perf_stall <= 32'd0;
        end else begin
            if (ins_valid && ins_ready && perf_ins != 32'hFFFF_FFFF)
                perf_ins <= perf_ins + 32'd1;
            if (ins_valid && !ins_ready && perf_stall != 32'hFFFF_FFFF)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_seq.sv
// ---------------------------------------------------------------------------
// tb_ifetch_seq
// Self-checking bench for ifetch_seq: directed fetches followed by random
// requests over a random memory image. Expected results come from an
// instruction-format model and are queued at request acceptance; a monitor
// compares them when the DUT presents each result.
// ---------------------------------------------------------------------------
module tb_ifetch_seq;

    localparam int MEM_BYTES = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_valid;
    logic        pc_ready;
    logic [63:0] pc_in;
    logic [63:0] mem_addr;
    logic [7:0]  mem_byte;
    logic        ins_valid;
    logic        ins_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic        ins_err;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_ins, perf_stall;
`endif

    logic [7:0] mem [MEM_BYTES];

    assign mem_byte = (mem_addr < 64'(MEM_BYTES)) ? mem[mem_addr[6:0]] : 8'hA5;

    ifetch_seq #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pc_valid (pc_valid),
        .pc_ready (pc_ready),
        .pc_in    (pc_in),
        .mem_addr (mem_addr),
        .mem_byte (mem_byte),
        .ins_valid(ins_valid),
        .ins_ready(ins_ready),
        .icode    (icode),
        .ifun     (ifun),
        .rA       (rA),
        .rB       (rB),
        .valC     (valC),
        .valP     (valP),
        .ins_err  (ins_err)
`ifdef IFETCH_PERF_EN
        ,
        .perf_ins  (perf_ins),
        .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic        err;
        int          lat;       // cycles from acceptance to first ins_valid
        int          acc_cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   hold_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Instruction length by icode; 0 marks an undefined icode.
    function automatic int ins_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       return 1;
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h7, 4'h8:             return 9;
            4'h3, 4'h4, 4'h5:       return 10;
            default:                return 0;
        endcase
    endfunction

    function automatic exp_t model(input logic [63:0] pc);
        exp_t        e;
        int          n, ok_bytes, cstart;
        logic [7:0]  op;
        logic [63:0] lim;
        e.icode = 4'h0; e.ifun = 4'h0; e.ra = 4'hF; e.rb = 4'hF;
        e.valc = 64'd0; e.valp = pc; e.err = 1'b0; e.lat = 2; e.acc_cyc = 0;
        lim = 64'(MEM_BYTES);
        if (pc >= lim) begin
            e.err = 1'b1;
            return e;
        end
        op = mem[pc[6:0]];
        e.icode = op[7:4];
        e.ifun  = op[3:0];
        n = ins_len(op[7:4]);
        if (n == 0) begin
            e.err = 1'b1;
            return e;
        end
        // Number of instruction bytes that lie inside memory.
        ok_bytes = ((lim - pc) >= 64'(n)) ? n : int'(lim - pc);
        if ((n == 2 || n == 10) && ok_bytes > 1) begin
            e.ra = mem[pc[6:0] + 7'd1][7:4];
            e.rb = mem[pc[6:0] + 7'd1][3:0];
        end
        if (ok_bytes < n) begin
            e.err = 1'b1;
            e.lat = ok_bytes + 2;
            return e;
        end
        cstart = (n == 10) ? 2 : 1;
        if (n >= 9)
            for (int k = 0; k < 8; k++)
                e.valc = e.valc | (64'(mem[pc[6:0] + 7'(cstart + k)]) << (8 * k));
        e.valp = pc + 64'(n);
        e.lat  = n + 1;
        return e;
    endfunction

    task automatic issue(input logic [63:0] pc);
        exp_t e;
        bit   done = 1'b0;
        @(posedge clk); #1;
        pc_valid = 1'b1;
        pc_in    = pc;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (pc_ready) begin
                e = model(pc);
                e.acc_cyc = cyc;
                q.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL accept_timeout: pc %0h not accepted", pc);
        end
        @(posedge clk); #1;
        pc_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (q.size() == 0 && pc_ready) done = 1'b1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL idle_timeout: %0d results outstanding", q.size());
            q.delete();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pc_ready"},  64'(pc_ready),  64'd1);
        check({tag, "_ins_valid"}, 64'(ins_valid), 64'd0);
        check({tag, "_ins_err"},   64'(ins_err),   64'd0);
        check({tag, "_mem_addr"},  mem_addr,       64'd0);
        check({tag, "_icode"},     64'(icode),     64'd0);
        check({tag, "_ifun"},      64'(ifun),      64'd0);
        check({tag, "_rA"},        64'(rA),        64'hF);
        check({tag, "_rB"},        64'(rB),        64'hF);
        check({tag, "_valC"},      valC,           64'd0);
        check({tag, "_valP"},      valP,           64'd0);
    endtask

    task automatic cmp_fields(input string tag, input exp_t e);
        check({tag, "_icode"}, 64'(icode),   64'(e.icode));
        check({tag, "_ifun"},  64'(ifun),    64'(e.ifun));
        check({tag, "_rA"},    64'(rA),      64'(e.ra));
        check({tag, "_rB"},    64'(rB),      64'(e.rb));
        check({tag, "_valC"},  valC,         e.valc);
        check({tag, "_valP"},  valP,         e.valp);
        check({tag, "_err"},   64'(ins_err), 64'(e.err));
    endtask

    // Decode-side ready: random unless a test holds it low.
    initial begin
        ins_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            ins_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: checks latency and fields on the first valid cycle, and
    // again at the handshake (which also proves the outputs held).
    initial begin
        bit fresh = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                fresh = 1'b1;
            end else if (ins_valid) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid: ins_valid with no request outstanding");
                    fresh = 1'b1;
                end else begin
                    if (fresh) begin
                        check("latency", 64'(cyc - q[0].acc_cyc), 64'(q[0].lat));
                        cmp_fields("first", q[0]);
                        fresh = 1'b0;
                    end
                    if (ins_ready) begin
                        cmp_fields("xfer", q[0]);
                        check("pc_ready_in_done", 64'(pc_ready), 64'd0);
                        void'(q.pop_front());
                        fresh = 1'b1;
                    end
                end
            end else if (ins_err) begin
                check("err_without_valid", 64'(ins_err), 64'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        pc_valid = 1'b0;
        pc_in    = 64'd0;
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        #1 check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // nop at 0
        mem[0] = 8'h10;
        issue(64'd0);
        wait_idle();

        // irmovq $8, %rdx at 5
        mem[5] = 8'h30; mem[6] = 8'hF2; mem[7] = 8'h08;
        for (int i = 8; i < 15; i++) mem[i] = 8'h00;
        issue(64'd5);
        wait_idle();

        // call 0x40 at 0
        mem[0] = 8'h80; mem[1] = 8'h40;
        for (int i = 2; i < 9; i++) mem[i] = 8'h00;
        issue(64'd0);
        wait_idle();

        // invalid icode, then a normal fetch
        mem[0] = 8'hC0;
        mem[20] = 8'h61; mem[21] = 8'h23;
        issue(64'd0);
        issue(64'd20);
        wait_idle();

        // irmovq at 120 runs off the end of memory at 128
        mem[120] = 8'h30; mem[121] = 8'hF2;
        for (int i = 122; i < 128; i++) mem[i] = 8'(i);
        issue(64'd120);
        wait_idle();

        // ret at 127 (last legal byte) and a pc far out of range
        mem[127] = 8'h90;
        issue(64'd127);
        issue(64'hFFFF_FFFF_FFFF_FFFF);
        wait_idle();

        // decode stalls for several cycles in DONE
        hold_ready = 1'b1;
        mem[30] = 8'hA0; mem[31] = 8'h4F;
        issue(64'd30);
        repeat (8) @(negedge clk);
        hold_ready = 1'b0;
        wait_idle();

        // reset pulse in the middle of the constant bytes
        issue(64'd5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset_vals("midreset");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(64'd5);
        wait_idle();

        // random image and random requests
        for (int i = 0; i < MEM_BYTES; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                                 : {4'($urandom_range(0, 11)), 4'($urandom)};
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 19) == 0)
                issue(64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7)));
            else
                issue(64'($urandom_range(0, MEM_BYTES + 3)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
